// File: rtl/clock_time_controller.sv
// HH:MM:SS timekeeper with RUN/SET_HR/SET_MIN button sequencing and BCD display
// mapping (12h/24h, blink blanking, colon) for the seven-segment scan driver.
module clock_time_controller #(
  parameter int CLKS_PER_HALFSEC = 25000000
) (
  input  logic       M_CLOCK,
  input  logic       M_RESET,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       fmt_12h,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] digit_blank,
  output logic       colon,
  output logic       pm,
  output logic       sec_tick
);

  // state     | meaning
  // S_RUN     | time advances on each second pulse
  // S_SET_HR  | up/down adjust hours, seconds frozen, hour digits blink
  // S_SET_MIN | up/down adjust minutes, seconds frozen, minute digits blink
  typedef enum logic [1:0] {S_RUN, S_SET_HR, S_SET_MIN} state_t;

  localparam int HSW = (CLKS_PER_HALFSEC > 1) ? $clog2(CLKS_PER_HALFSEC) : 1;
  localparam logic [HSW-1:0] HS_LAST = HSW'(CLKS_PER_HALFSEC - 1);

  state_t         r_state, w_state_nxt;
  logic [4:0]     r_hours, w_hours_nxt;
  logic [5:0]     r_min, w_min_nxt;
  logic [5:0]     r_sec, w_sec_nxt;
  logic [HSW-1:0] r_hs_cnt;
  logic           r_phase;
  logic           r_mode_prev, r_up_prev, r_down_prev;
  logic           w_restart, w_tick_nxt;

  logic w_hs_wrap, w_sec_pulse, w_mode_e, w_up_e, w_down_e, w_up, w_down;

  assign w_hs_wrap   = (r_hs_cnt == HS_LAST);
  assign w_sec_pulse = w_hs_wrap & r_phase;
  assign w_mode_e    = btn_mode & ~r_mode_prev;
  assign w_up_e      = btn_up & ~r_up_prev;
  assign w_down_e    = btn_down & ~r_down_prev;
  // Mode beats up/down, and opposing edges cancel.
  assign w_up        = w_up_e & ~w_down_e & ~w_mode_e;
  assign w_down      = w_down_e & ~w_up_e & ~w_mode_e;

  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hours_nxt = r_hours;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_restart   = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mode_e) w_state_nxt = S_SET_HR;
        if (w_sec_pulse) begin
          w_tick_nxt = 1'b1;
          if (r_sec == 6'd59) begin
            w_sec_nxt = 6'd0;
            if (r_min == 6'd59) begin
              w_min_nxt   = 6'd0;
              w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
            end else begin
              w_min_nxt = r_min + 6'd1;
            end
          end else begin
            w_sec_nxt = r_sec + 6'd1;
          end
        end
      end
      S_SET_HR: begin
        if (w_mode_e)    w_state_nxt = S_SET_MIN;
        else if (w_up)   w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
        else if (w_down) w_hours_nxt = (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
      end
      S_SET_MIN: begin
        if (w_mode_e) begin
          w_state_nxt = S_RUN;
          w_sec_nxt   = 6'd0;
          w_restart   = 1'b1;
        end else if (w_up) begin
          w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        end else if (w_down) begin
          w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  logic [4:0] w_disp_hr;
  logic [7:0] w_hr_bcd, w_min_bcd;
  logic [3:0] w_blank;
  logic       w_colon, w_pm;

  always_comb begin
    w_disp_hr = r_hours;
    if (fmt_12h) begin
      if (r_hours == 5'd0)      w_disp_hr = 5'd12;
      else if (r_hours > 5'd12) w_disp_hr = r_hours - 5'd12;
    end
  end

  assign w_hr_bcd  = to_bcd({1'b0, w_disp_hr});
  assign w_min_bcd = to_bcd(r_min);
  assign w_pm      = fmt_12h & (r_hours >= 5'd12);
  assign w_colon   = (r_state == S_RUN) ? ~r_phase : 1'b1;
  assign w_blank[3] = (fmt_12h & (w_hr_bcd[7:4] == 4'd0)) | ((r_state == S_SET_HR) & r_phase);
  assign w_blank[2] = (r_state == S_SET_HR) & r_phase;
  assign w_blank[1] = (r_state == S_SET_MIN) & r_phase;
  assign w_blank[0] = (r_state == S_SET_MIN) & r_phase;

  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) begin
      r_hours     <= 5'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_hs_cnt    <= '0;
      r_phase     <= 1'b0;
      // Load current levels so a button held through reset yields no edge.
      r_mode_prev <= btn_mode;
      r_up_prev   <= btn_up;
      r_down_prev <= btn_down;
      hour_tens   <= 4'd0;
      hour_ones   <= 4'd0;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      digit_blank <= 4'd0;
      colon       <= 1'b0;
      pm          <= 1'b0;
      sec_tick    <= 1'b0;
    end else begin
      r_hours     <= w_hours_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_mode_prev <= btn_mode;
      r_up_prev   <= btn_up;
      r_down_prev <= btn_down;
      if (w_restart) begin
        r_hs_cnt <= '0;
        r_phase  <= 1'b0;
      end else if (w_hs_wrap) begin
        r_hs_cnt <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_hs_cnt <= r_hs_cnt + 1'b1;
      end
      hour_tens   <= w_hr_bcd[7:4];
      hour_ones   <= w_hr_bcd[3:0];
      min_tens    <= w_min_bcd[7:4];
      min_ones    <= w_min_bcd[3:0];
      digit_blank <= w_blank;
      colon       <= w_colon;
      pm          <= w_pm;
      sec_tick    <= w_tick_nxt;
    end
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with CLKS_PER_HALFSEC=4 (1 s = 8 cycles).
module tb_clock_time_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, fmt_12h = 1'b0;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones, digit_blank;
  logic       colon, pm, sec_tick;

  int tests = 0;
  int fails = 0;
  int n_edge = 0;

  clock_time_controller #(.CLKS_PER_HALFSEC(4)) dut (
    .M_CLOCK(clk), .M_RESET(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .fmt_12h(fmt_12h),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens), .min_ones(min_ones),
    .digit_blank(digit_blank), .colon(colon), .pm(pm), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; the half-second phase follows from it.
  always @(posedge clk) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // which: 0 = mode, 1 = up, 2 = down
  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1;
    if (which == 1) btn_up = 1'b1;
    if (which == 2) btn_down = 1'b1;
    step(1);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(1);
  endtask

  function automatic int run_colon(input int ne);
    return (((ne - 1) / 4) % 2 == 0) ? 1 : 0;
  endfunction

  // Leave SET_MIN with a mode edge, then watch ncyc cycles counted from that edge.
  task automatic exit_and_run(input int ncyc, output int first, output int nticks, output int bad_hr);
    first = -1; nticks = 0; bad_hr = 0;
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      step(1);
      if (sec_tick) begin
        nticks++;
        if (first < 0) first = k;
      end
      if (hour_tens > 4'd2 || (hour_tens == 4'd2 && hour_ones > 4'd3)) bad_hr++;
    end
  endtask

  int tick_cnt, bad_tick, bad_colon, bad_blank, bad_stick, first, nticks, bad_hr;

  initial begin
    // 1: reset state and one free-running minute in 24h
    do_reset();
    check("rst_hour_tens", hour_tens, 0);
    check("rst_min_ones", min_ones, 0);
    check("rst_blank", digit_blank, 0);
    check("rst_colon", colon, 0);
    check("rst_tick", sec_tick, 0);
    tick_cnt = 0; bad_tick = 0; bad_colon = 0;
    for (int i = 1; i <= 480; i++) begin
      step(1);
      if (sec_tick) tick_cnt++;
      if (int'(sec_tick) != ((i % 8 == 0) ? 1 : 0)) bad_tick++;
      if (int'(colon) != ((((i - 1) % 8) < 4) ? 1 : 0)) bad_colon++;
    end
    check("run_tick_count", tick_cnt, 60);
    check("run_tick_spacing_errs", bad_tick, 0);
    check("run_colon_errs", bad_colon, 0);
    step(1);
    check("run_min_ones", min_ones, 1);
    check("run_min_tens", min_tens, 0);
    check("run_hour_ones", hour_ones, 0);
    check("run_hour_tens", hour_tens, 0);

    // 2: set 23:59 and roll over to 00:00
    do_reset();
    press(0); press(2); press(0); press(2);
    check("set_2359_ht", hour_tens, 2);
    check("set_2359_ho", hour_ones, 3);
    check("set_2359_mt", min_tens, 5);
    check("set_2359_mo", min_ones, 9);
    exit_and_run(481, first, nticks, bad_hr);
    check("roll_first_tick", first, 8);
    check("roll_tick_count", nticks, 60);
    check("roll_no_hour24", bad_hr, 0);
    check("roll_ht", hour_tens, 0);
    check("roll_ho", hour_ones, 0);
    check("roll_mt", min_tens, 0);
    check("roll_mo", min_ones, 0);

    // 3: SET_HR wraps and simultaneous events
    do_reset();
    press(0);
    press(2);
    check("hr_down_wrap_t", hour_tens, 2);
    check("hr_down_wrap_o", hour_ones, 3);
    press(1);
    check("hr_up_wrap_t", hour_tens, 0);
    check("hr_up_wrap_o", hour_ones, 0);
    btn_up = 1'b1; btn_down = 1'b1;
    step(1);
    btn_up = 1'b0; btn_down = 1'b0;
    step(1);
    check("hr_updown_cancel", hour_ones, 0);
    btn_mode = 1'b1; btn_up = 1'b1;
    step(1);
    btn_mode = 1'b0; btn_up = 1'b0;
    step(1);
    check("mode_wins_hr", hour_ones, 0);
    press(1);
    check("setmin_up_min", min_ones, 1);
    check("setmin_up_hr", hour_ones, 0);

    // 5: SET_MIN blink, colon steady, restart on exit
    bad_blank = 0; bad_colon = 0; bad_stick = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (int'(digit_blank) != ((run_colon(n_edge) == 1) ? 0 : 3)) bad_blank++;
      if (colon !== 1'b1) bad_colon++;
      if (sec_tick !== 1'b0) bad_stick++;
    end
    check("setmin_blank_errs", bad_blank, 0);
    check("setmin_colon_errs", bad_colon, 0);
    check("setmin_tick_errs", bad_stick, 0);
    exit_and_run(20, first, nticks, bad_hr);
    check("exit_first_tick", first, 8);
    check("exit_tick_count", nticks, 2);
    check("exit_min_kept", min_ones, 1);

    // 4: 12h display mapping
    fmt_12h = 1'b1;
    do_reset();
    step(1);
    check("h12_0_tens", hour_tens, 1);
    check("h12_0_ones", hour_ones, 2);
    check("h12_0_pm", pm, 0);
    check("h12_0_blank", digit_blank, 0);
    press(0);
    for (int i = 0; i < 13; i++) press(1);
    check("h12_13_tens", hour_tens, 0);
    check("h12_13_ones", hour_ones, 1);
    check("h12_13_blank3", digit_blank[3], 1);
    check("h12_13_pm", pm, 1);
    press(2);
    check("h12_12_tens", hour_tens, 1);
    check("h12_12_ones", hour_ones, 2);
    check("h12_12_pm", pm, 1);
    fmt_12h = 1'b0;
    step(1);
    check("h24_12_pm", pm, 0);
    check("h24_12_ones", hour_ones, 2);

    // 6: reset mid-SET_MIN with up held, then mode held through reset
    do_reset();
    press(0); press(0); press(1); press(1);
    check("pre_rst_min", min_ones, 2);
    rst = 1'b1; btn_up = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_min", min_ones, 0);
    check("mid_rst_hr", hour_ones, 0);
    check("mid_rst_blank", digit_blank, 0);
    check("mid_rst_colon", colon, 0);
    check("mid_rst_pm", pm, 0);
    check("mid_rst_tick", sec_tick, 0);
    step(3);
    btn_up = 1'b0;
    step(2);
    check("post_rst_min", min_ones, 0);
    check("post_rst_colon", colon, run_colon(n_edge));
    rst = 1'b1; btn_mode = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    btn_mode = 1'b0;
    step(4);
    check("held_mode_colon", colon, run_colon(n_edge));
    check("held_mode_blank", digit_blank, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
